// File: rtl/tty_screen_writer.sv
// tty_screen_writer: turns a valid/ready byte stream into text-screen RAM cell writes.
// It tracks the cursor and the colour attribute, decodes CR/LF/BS/TAB/FF, wraps long
// lines, wraps the cursor from the bottom row back to the top, and clears lines and
// the whole screen.
// Ports:
//   pixel_clock, reset_n          clock, synchronous active-low reset
//   char_data/char_valid/char_ready   byte stream in (valid/ready)
//   attr_wr/attr_data             one-cycle strobe loading {bg, fg}
//   wrdata/wradr/wren             screen RAM write port ({0,bg,0,fg,char} at {row,col})
//   cursor_col/cursor_row         current cursor position
//   busy                          a line or screen clear is in progress
module tty_screen_writer #(
   parameter int unsigned COLS   = 90,
   parameter int unsigned ROWS   = 56,
   parameter logic [2:0]  DEF_FG = 3'd7,
   parameter logic [2:0]  DEF_BG = 3'd1
) (
   input  logic        pixel_clock,
   input  logic        reset_n,
   input  logic [7:0]  char_data,
   input  logic        char_valid,
   output logic        char_ready,
   input  logic        attr_wr,
   input  logic [5:0]  attr_data,
   output logic [15:0] wrdata,
   output logic [12:0] wradr,
   output logic        wren,
   output logic [6:0]  cursor_col,
   output logic [5:0]  cursor_row,
   output logic        busy
);

   localparam int unsigned COL_W = 7;
   localparam int unsigned ROW_W = 6;
   localparam int unsigned ADR_W = COL_W + ROW_W;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      PUT     = 2'd1,
      CLRLINE = 2'd2,
      CLRSCR  = 2'd3
   } state_t;

   state_t             state, state_nxt;
   logic [COL_W-1:0]   col, col_nxt;
   logic [ROW_W-1:0]   row, row_nxt;
   logic [ADR_W-1:0]   cnt, cnt_nxt;
   logic [2:0]         fg, fg_nxt, bg, bg_nxt;
   logic               wren_nxt;
   logic [ADR_W-1:0]   wradr_nxt;
   logic [15:0]        wrdata_nxt;

   logic               accept;
   logic [ROW_W-1:0]   row_adv;
   logic [COL_W:0]     tab_col;
   logic [15:0]        blank;

   assign accept  = char_valid && (state == IDLE);
   // Cursor moves back to the top row instead of scrolling.
   assign row_adv = (row == ROW_W'(ROWS - 1)) ? '0 : row + ROW_W'(1);
   // Next multiple-of-8 tab stop; one extra bit so col 127 does not overflow.
   assign tab_col = ({1'b0, col} | (COL_W+1)'(7)) + (COL_W+1)'(1);
   assign blank   = {1'b0, bg, 1'b0, fg, 8'h20};

   // State and datapath registers.
   always_ff @(posedge pixel_clock) begin
      if (!reset_n) begin
         state  <= CLRSCR;
         col    <= '0;
         row    <= '0;
         cnt    <= '0;
         fg     <= DEF_FG;
         bg     <= DEF_BG;
         wren   <= 1'b0;
         wradr  <= '0;
         wrdata <= '0;
      end else begin
         state  <= state_nxt;
         col    <= col_nxt;
         row    <= row_nxt;
         cnt    <= cnt_nxt;
         fg     <= fg_nxt;
         bg     <= bg_nxt;
         wren   <= wren_nxt;
         wradr  <= wradr_nxt;
         wrdata <= wrdata_nxt;
      end
   end

   // Next state, cursor, clear counter and the write to present next cycle.
   always_comb begin
      state_nxt  = state;
      col_nxt    = col;
      row_nxt    = row;
      cnt_nxt    = cnt;
      fg_nxt     = attr_wr ? attr_data[2:0] : fg;
      bg_nxt     = attr_wr ? attr_data[5:3] : bg;
      wren_nxt   = 1'b0;
      wradr_nxt  = wradr;
      wrdata_nxt = wrdata;

      case (state)
         IDLE: begin
            if (accept) begin
               case (char_data)
                  8'h0D: col_nxt = '0;
                  8'h08: if (col != '0) col_nxt = col - COL_W'(1);
                  8'h0A: begin
                     col_nxt   = '0;
                     row_nxt   = row_adv;
                     cnt_nxt   = '0;
                     state_nxt = CLRLINE;
                  end
                  8'h09: begin
                     if (tab_col >= (COL_W+1)'(COLS)) begin
                        col_nxt   = '0;
                        row_nxt   = row_adv;
                        cnt_nxt   = '0;
                        state_nxt = CLRLINE;
                     end else begin
                        col_nxt = tab_col[COL_W-1:0];
                     end
                  end
                  8'h0C: begin
                     col_nxt   = '0;
                     row_nxt   = '0;
                     cnt_nxt   = '0;
                     state_nxt = CLRSCR;
                  end
                  default: begin
                     // Character cell is written in the cycle after accept,
                     // with the attribute in force before any same-cycle attr_wr.
                     state_nxt  = PUT;
                     wren_nxt   = 1'b1;
                     wradr_nxt  = {row, col};
                     wrdata_nxt = {1'b0, bg, 1'b0, fg, char_data};
                  end
               endcase
            end
         end
         PUT: begin
            if (col == COL_W'(COLS - 1)) begin
               col_nxt   = '0;
               row_nxt   = row_adv;
               cnt_nxt   = '0;
               state_nxt = CLRLINE;
            end else begin
               col_nxt   = col + COL_W'(1);
               state_nxt = IDLE;
            end
         end
         CLRLINE: begin
            if (cnt[COL_W-1:0] == COL_W'(COLS - 1)) state_nxt = IDLE;
            else                                    cnt_nxt   = cnt + ADR_W'(1);
         end
         CLRSCR: begin
            // wren low here only right after reset: address 0 not yet written.
            if (!wren) begin
               cnt_nxt = cnt;
            end else if (cnt == '1) begin
               cnt_nxt   = '0;
               state_nxt = IDLE;
            end else begin
               cnt_nxt = cnt + ADR_W'(1);
            end
         end
         default: state_nxt = IDLE;
      endcase

      // Clear writes track the counter of the state being entered/continued.
      if (state_nxt == CLRLINE) begin
         wren_nxt   = 1'b1;
         wradr_nxt  = {row_nxt, cnt_nxt[COL_W-1:0]};
         wrdata_nxt = blank;
      end else if (state_nxt == CLRSCR) begin
         wren_nxt   = 1'b1;
         wradr_nxt  = cnt_nxt;
         wrdata_nxt = blank;
      end
   end

   // Moore outputs decoded from the state register.
   always_comb begin
      char_ready = (state == IDLE);
      busy       = (state == CLRLINE) || (state == CLRSCR);
   end

   assign cursor_col = col;
   assign cursor_row = row;

endmodule

// File: tb/tb_tty_screen_writer.sv
// tb_tty_screen_writer: directed scenarios for tty_screen_writer with hand-computed
// expected writes, cursor positions and handshake levels.
module tb_tty_screen_writer;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic [7:0]  char_data = 8'h00;
   logic        char_valid = 1'b0;
   logic        char_ready;
   logic        attr_wr = 1'b0;
   logic [5:0]  attr_data = 6'h00;
   logic [15:0] wrdata;
   logic [12:0] wradr;
   logic        wren;
   logic [6:0]  cursor_col;
   logic [5:0]  cursor_row;
   logic        busy;

   int n_cmp = 0;
   int n_err = 0;

   tty_screen_writer dut (
      .pixel_clock(clk),
      .reset_n    (reset_n),
      .char_data  (char_data),
      .char_valid (char_valid),
      .char_ready (char_ready),
      .attr_wr    (attr_wr),
      .attr_data  (attr_data),
      .wrdata     (wrdata),
      .wradr      (wradr),
      .wren       (wren),
      .cursor_col (cursor_col),
      .cursor_row (cursor_row),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   task automatic wait_ready();
      int n = 0;
      while (char_ready !== 1'b1 && n < 20000) begin
         @(negedge clk);
         n++;
      end
      n_cmp++;
      if (n >= 20000) begin
         n_err++;
         $display("FAIL wait_ready: char_ready=%b after %0d cycles, required 1", char_ready, n);
      end
   endtask

   // Presents one byte (optionally with an attr_wr strobe) until accepted; returns #1 after accept edge.
   task automatic send_byte(input logic [7:0] b, input logic aw, input logic [5:0] ad);
      wait_ready();
      char_data  = b;
      char_valid = 1'b1;
      attr_wr    = aw;
      attr_data  = ad;
      @(posedge clk);
      #1;
      char_valid = 1'b0;
      attr_wr    = 1'b0;
      char_data  = 8'($urandom);
   endtask

   // Samples n consecutive cycles of a clear and checks address/data sequence.
   task automatic check_clear(input string name, input int n, input logic [12:0] base,
                              input logic [15:0] data);
      int bad = 0;
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         if (wren !== 1'b1 || wradr !== base + 13'(i) || wrdata !== data || busy !== 1'b1) begin
            if (bad == 0)
               $display("FAIL %s: cycle %0d wren=%b wradr=%h wrdata=%h busy=%b, required 1/%h/%h/1",
                        name, i, wren, wradr, wrdata, busy, base + 13'(i), data);
            bad++;
         end
      end
      n_cmp++;
      if (bad != 0) begin
         n_err++;
         $display("FAIL %s: %0d bad cycles, required 0", name, bad);
      end
   endtask

   task automatic test_reset();
      repeat (3) @(negedge clk);
      n_cmp++;
      if ({wren, wradr, wrdata, cursor_col, cursor_row, char_ready} !== 44'h0) begin
         n_err++;
         $display("FAIL reset_values: wren=%b wradr=%h wrdata=%h col=%0d row=%0d ready=%b, required all 0",
                  wren, wradr, wrdata, cursor_col, cursor_row, char_ready);
      end
      reset_n = 1'b1;
      check_clear("reset_clrscr", 8192, 13'h0000, 16'h1720);
      @(negedge clk);
      n_cmp++;
      if (wren !== 1'b0 || char_ready !== 1'b1 || busy !== 1'b0 || cursor_col !== 7'd0 || cursor_row !== 6'd0) begin
         n_err++;
         $display("FAIL reset_done: wren=%b ready=%b busy=%b col=%0d row=%0d, required 0/1/0/0/0",
                  wren, char_ready, busy, cursor_col, cursor_row);
      end
   endtask

   task automatic test_put();
      send_byte(8'h41, 1'b0, 6'h00);
      @(negedge clk);
      n_cmp++;
      if (wren !== 1'b1 || wradr !== 13'h0000 || wrdata !== 16'h1741 || char_ready !== 1'b0) begin
         n_err++;
         $display("FAIL put_write: wren=%b wradr=%h wrdata=%h ready=%b, required 1/0000/1741/0",
                  wren, wradr, wrdata, char_ready);
      end
      @(negedge clk);
      n_cmp++;
      if (cursor_col !== 7'd1 || char_ready !== 1'b1 || wren !== 1'b0) begin
         n_err++;
         $display("FAIL put_after: col=%0d ready=%b wren=%b, required 1/1/0", cursor_col, char_ready, wren);
      end
   endtask

   task automatic test_row_fill();
      int bad = 0;
      logic [7:0] ch;
      send_byte(8'h0D, 1'b0, 6'h00);
      for (int i = 0; i < 90; i++) begin
         ch = 8'h30 + 8'(i % 10);
         send_byte(ch, 1'b0, 6'h00);
         @(negedge clk);
         if (wren !== 1'b1 || wradr !== 13'(i) || wrdata !== {8'h17, ch}) bad++;
      end
      n_cmp++;
      if (bad != 0) begin
         n_err++;
         $display("FAIL row_fill_writes: %0d bad writes, required 0", bad);
      end
      n_cmp++;
      if (wradr !== 13'h059) begin
         n_err++;
         $display("FAIL row_fill_last: wradr=%h, required 0059", wradr);
      end
      @(negedge clk);
      n_cmp++;
      if (cursor_col !== 7'd0 || cursor_row !== 6'd1) begin
         n_err++;
         $display("FAIL wrap_cursor: col=%0d row=%0d, required 0/1", cursor_col, cursor_row);
      end
      // First wrap-clear cycle was just sampled; check it plus the remaining 89.
      n_cmp++;
      if (wren !== 1'b1 || wradr !== 13'h080 || wrdata !== 16'h1720) begin
         n_err++;
         $display("FAIL wrap_clr_first: wren=%b wradr=%h wrdata=%h, required 1/0080/1720", wren, wradr, wrdata);
      end
      check_clear("wrap_clrline", 89, 13'h081, 16'h1720);
      @(negedge clk);
      n_cmp++;
      if (wren !== 1'b0 || char_ready !== 1'b1) begin
         n_err++;
         $display("FAIL wrap_clr_end: wren=%b ready=%b, required 0/1", wren, char_ready);
      end
   endtask

   task automatic test_controls();
      for (int i = 0; i < 54; i++) send_byte(8'h0A, 1'b0, 6'h00);
      wait_ready();
      n_cmp++;
      if (cursor_row !== 6'd55 || cursor_col !== 7'd0) begin
         n_err++;
         $display("FAIL lf_walk: row=%0d col=%0d, required 55/0", cursor_row, cursor_col);
      end
      send_byte(8'h0A, 1'b0, 6'h00);
      n_cmp++;
      if (cursor_row !== 6'd0 || cursor_col !== 7'd0) begin
         n_err++;
         $display("FAIL lf_rowwrap: row=%0d col=%0d, required 0/0", cursor_row, cursor_col);
      end
      check_clear("lf_clrline_row0", 90, 13'h000, 16'h1720);
      for (int i = 0; i < 40; i++) send_byte(8'h78, 1'b0, 6'h00);
      wait_ready();
      n_cmp++;
      if (cursor_col !== 7'd40) begin
         n_err++;
         $display("FAIL col40: col=%0d, required 40", cursor_col);
      end
      send_byte(8'h0D, 1'b0, 6'h00);
      @(negedge clk);
      n_cmp++;
      if (cursor_col !== 7'd0 || wren !== 1'b0 || char_ready !== 1'b1) begin
         n_err++;
         $display("FAIL cr: col=%0d wren=%b ready=%b, required 0/0/1", cursor_col, wren, char_ready);
      end
      send_byte(8'h08, 1'b0, 6'h00);
      @(negedge clk);
      n_cmp++;
      if (cursor_col !== 7'd0 || wren !== 1'b0) begin
         n_err++;
         $display("FAIL bs_col0: col=%0d wren=%b, required 0/0", cursor_col, wren);
      end
      for (int i = 0; i < 3; i++) send_byte(8'h79, 1'b0, 6'h00);
      send_byte(8'h09, 1'b0, 6'h00);
      @(negedge clk);
      n_cmp++;
      if (cursor_col !== 7'd8 || wren !== 1'b0 || char_ready !== 1'b1) begin
         n_err++;
         $display("FAIL tab_col3: col=%0d wren=%b ready=%b, required 8/0/1", cursor_col, wren, char_ready);
      end
      send_byte(8'h08, 1'b0, 6'h00);
      @(negedge clk);
      n_cmp++;
      if (cursor_col !== 7'd7 || wren !== 1'b0) begin
         n_err++;
         $display("FAIL bs_col8: col=%0d wren=%b, required 7/0", cursor_col, wren);
      end
      send_byte(8'h09, 1'b0, 6'h00);
      @(negedge clk);
      n_cmp++;
      if (cursor_col !== 7'd8) begin
         n_err++;
         $display("FAIL tab_col7: col=%0d, required 8", cursor_col);
      end
      for (int i = 0; i < 80; i++) send_byte(8'h7A, 1'b0, 6'h00);
      wait_ready();
      n_cmp++;
      if (cursor_col !== 7'd88 || cursor_row !== 6'd0) begin
         n_err++;
         $display("FAIL col88: col=%0d row=%0d, required 88/0", cursor_col, cursor_row);
      end
      send_byte(8'h09, 1'b0, 6'h00);
      @(negedge clk);
      n_cmp++;
      if (cursor_col !== 7'd0 || cursor_row !== 6'd1 || wren !== 1'b1 || wradr !== 13'h080 || busy !== 1'b1) begin
         n_err++;
         $display("FAIL tab_newline: col=%0d row=%0d wren=%b wradr=%h busy=%b, required 0/1/1/0080/1",
                  cursor_col, cursor_row, wren, wradr, busy);
      end
      wait_ready();
   endtask

   task automatic test_attr();
      send_byte(8'h42, 1'b1, 6'b010_100);
      @(negedge clk);
      n_cmp++;
      if (wren !== 1'b1 || wradr !== 13'h080 || wrdata !== 16'h1742) begin
         n_err++;
         $display("FAIL attr_same_cycle: wren=%b wradr=%h wrdata=%h, required 1/0080/1742", wren, wradr, wrdata);
      end
      send_byte(8'h43, 1'b0, 6'h00);
      @(negedge clk);
      n_cmp++;
      if (wren !== 1'b1 || wradr !== 13'h081 || wrdata !== 16'h2443) begin
         n_err++;
         $display("FAIL attr_next_char: wren=%b wradr=%h wrdata=%h, required 1/0081/2443", wren, wradr, wrdata);
      end
      send_byte(8'h0C, 1'b0, 6'h00);
      n_cmp++;
      if (cursor_col !== 7'd0 || cursor_row !== 6'd0) begin
         n_err++;
         $display("FAIL ff_cursor: col=%0d row=%0d, required 0/0", cursor_col, cursor_row);
      end
      check_clear("ff_clrscr", 8192, 13'h0000, 16'h2420);
      @(negedge clk);
      n_cmp++;
      if (wren !== 1'b0 || char_ready !== 1'b1) begin
         n_err++;
         $display("FAIL ff_end: wren=%b ready=%b, required 0/1", wren, char_ready);
      end
   endtask

   task automatic test_reset_midline();
      send_byte(8'h0A, 1'b0, 6'h00);
      repeat (40) @(negedge clk);
      reset_n = 1'b0;
      @(negedge clk);
      n_cmp++;
      if (wren !== 1'b0 || wradr !== 13'h0 || wrdata !== 16'h0 || cursor_row !== 6'd0 || char_ready !== 1'b0) begin
         n_err++;
         $display("FAIL midline_reset: wren=%b wradr=%h wrdata=%h row=%0d ready=%b, required 0/0000/0000/0/0",
                  wren, wradr, wrdata, cursor_row, char_ready);
      end
      @(negedge clk);
      reset_n = 1'b1;
      check_clear("restart_clrscr", 8192, 13'h0000, 16'h1720);
      @(negedge clk);
      n_cmp++;
      if (char_ready !== 1'b1 || cursor_col !== 7'd0 || cursor_row !== 6'd0) begin
         n_err++;
         $display("FAIL restart_done: ready=%b col=%0d row=%0d, required 1/0/0", char_ready, cursor_col, cursor_row);
      end
   endtask

   initial begin
      test_reset();
      test_put();
      test_row_fill();
      test_controls();
      test_attr();
      test_reset_midline();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
